// File: rtl/seg_display_scheduler.sv
// Round-robin time-sharing of one 8-digit seven-segment display.
// Grants one requester per dwell slot and forwards its 32-bit word.
module seg_display_scheduler #(
    parameter int NUM_SRC      = 4,
    parameter int DWELL_CYCLES = 100_000_000
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [NUM_SRC-1:0]      req_in,
    input  logic [32*NUM_SRC-1:0]   val_in,
    input  logic                    hold_in,
    output logic [31:0]             val_out,
    output logic [NUM_SRC-1:0]      grant_out,
    output logic                    active_out,
    output logic                    switch_out
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DWELL_CYCLES - 1);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_SRC - 1);

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        last_q, last_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_SRC-1:0]   grant_q, grant_d;
    logic [31:0]          val_q, val_d;
    logic                 switch_q, switch_d;
    logic                 found;
    logic [IW-1:0]        nxt;

    // Round-robin search starting after last grant; the last grant is checked last.
    always_comb begin
        int j;
        found = 1'b0;
        nxt   = last_q;
        j     = 0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            j = (int'(last_q) + k) % NUM_SRC;
            if (req_in[j]) begin
                found = 1'b1;
                nxt   = IW'(j);
            end
        end
    end

    // Next state: drop of current request beats hold, hold beats expiry.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        switch_d = 1'b0;
        grant_d  = '0;
        val_d    = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = SHOW;
                    last_d   = nxt;
                    cnt_d    = '0;
                    switch_d = 1'b1;
                end
            end
            SHOW: begin
                if (!req_in[last_q]) begin
                    cnt_d = '0;
                    if (found) begin
                        last_d   = nxt;
                        switch_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (hold_in) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d    = '0;
                    last_d   = nxt;
                    switch_d = (nxt != last_q);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d == SHOW) begin
            grant_d[last_d] = 1'b1;
            val_d = val_in[32*int'(last_d) +: 32];
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            last_q   <= LAST_RST;
            cnt_q    <= '0;
            grant_q  <= '0;
            val_q    <= 32'h0;
            switch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            val_q    <= val_d;
            switch_q <= switch_d;
        end
    end

    assign val_out    = val_q;
    assign grant_out  = grant_q;
    assign active_out = (state_q == SHOW);
    assign switch_out = switch_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler.
// NUM_SRC=4, DWELL_CYCLES=4, source i word = A000_0000 + i.
module tb_seg_display_scheduler;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic [3:0]   req_in;
    logic [127:0] val_in;
    logic         hold_in;
    logic [31:0]  val_out;
    logic [3:0]   grant_out;
    logic         active_out;
    logic         switch_out;

    int n_chk  = 0;
    int n_pass = 0;

    seg_display_scheduler #(
        .NUM_SRC      (4),
        .DWELL_CYCLES (4)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .req_in     (req_in),
        .val_in     (val_in),
        .hold_in    (hold_in),
        .val_out    (val_out),
        .grant_out  (grant_out),
        .active_out (active_out),
        .switch_out (switch_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic init_vals();
        for (int i = 0; i < 4; i++) val_in[32*i +: 32] = 32'hA000_0000 + i;
    endtask

    task automatic do_reset();
        rst_in  = 1'b1;
        req_in  = 4'b0000;
        hold_in = 1'b0;
        init_vals();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [3:0] g,
                             input logic [31:0] v, input logic a,
                             input logic s);
        check({tag, ".grant"}, 32'(grant_out), 32'(g));
        check({tag, ".val"}, val_out, v);
        check({tag, ".active"}, 32'(active_out), 32'(a));
        check({tag, ".switch"}, 32'(switch_out), 32'(s));
    endtask

    initial begin
        // 1: reset then no requests
        do_reset();
        check_all("rst", 4'b0000, 32'h0, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            tick();
            check_all("idle", 4'b0000, 32'h0, 1'b0, 1'b0);
        end

        // 2: all requesting, rotate 0,1,2,3,0 with 4-cycle slots
        do_reset();
        req_in = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                check_all("rr", 4'b0001 << (s % 4),
                          32'hA000_0000 + (s % 4), 1'b1, (c == 0));
            end
        end

        // 3: single requester held, live value tracking
        do_reset();
        req_in = 4'b0100;
        tick();
        check_all("single", 4'b0100, 32'hA000_0002, 1'b1, 1'b1);
        for (int c = 0; c < 10; c++) begin
            tick();
            check_all("single_hold", 4'b0100, 32'hA000_0002, 1'b1, 1'b0);
        end
        val_in[64 +: 32] = 32'h1234_5678;
        tick();
        check("live_val", val_out, 32'h1234_5678);

        // 4: drop of granted request mid-slot, then all drop
        do_reset();
        req_in = 4'b1010;
        tick();
        check_all("grant1", 4'b0010, 32'hA000_0001, 1'b1, 1'b1);
        tick();
        req_in = 4'b1000;
        tick();
        check_all("drop1", 4'b1000, 32'hA000_0003, 1'b1, 1'b1);
        req_in = 4'b0000;
        tick();
        check_all("drop3", 4'b0000, 32'h0, 1'b0, 1'b0);

        // 5: hold freezes rotation; release rotates next cycle
        do_reset();
        req_in  = 4'b0011;
        hold_in = 1'b1;
        tick();
        check_all("hold_g0", 4'b0001, 32'hA000_0000, 1'b1, 1'b1);
        for (int c = 0; c < 20; c++) begin
            tick();
            check("hold_grant", 32'(grant_out), 32'h1);
        end
        hold_in = 1'b0;
        tick();
        check_all("hold_rel", 4'b0010, 32'hA000_0001, 1'b1, 1'b1);

        // 6: reset mid-slot, re-arbitrate from index 0
        do_reset();
        req_in = 4'b0100;
        tick();
        check("pre_rst", 32'(grant_out), 32'h4);
        req_in = 4'b1100;
        tick();
        rst_in = 1'b1;
        tick();
        check_all("mid_rst", 4'b0000, 32'h0, 1'b0, 1'b0);
        rst_in = 1'b0;
        tick();
        check_all("post_rst", 4'b0100, 32'hA000_0002, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
- Time-shares the single 8-digit seven-segment display between up to NUM_SRC requesters, e.g. UART RX byte log, TX byte log, error counter and debug word.
- Grants one requester at a time, round-robin, for DWELL_CYCLES per slot.
- Drives the 32-bit hex word that feeds seven_segment_controller's val_in.
- Sits between the producing datapaths and the display controller.

Parameters:
NUM_SRC, 4, number of requesters (legal 2..8)
DWELL_CYCLES, 100_000_000, clock cycles each granted source is shown (1 s at 100 MHz); legal >= 2

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, synchronous, active-high
req_in  input  NUM_SRC  per-source request; level, held high while source wants display time
val_in  input  32*NUM_SRC  source i word at bits [32*i+31 : 32*i]
hold_in  input  1  freeze rotation on current source while high
val_out  output  32  word to seven_segment_controller val_in
grant_out  output  NUM_SRC  one-hot current grant; all-zero when idle
active_out  output  1  high while any source granted (state SHOW)
switch_out  output  1  one-cycle pulse when grant changes to a different nonzero source

Behaviour:
- One clock, clk_in. Reset is synchronous and active-high on rst_in. All outputs registered.
- Reset values: state IDLE, grant_out 0, val_out 32'h0, active_out 0, switch_out 0, dwell counter 0, last-grant pointer NUM_SRC-1, so the first search starts at source 0.
- Round-robin search (next): scan indices last+1, last+2, ... wrapping mod NUM_SRC. Stop at the first with req_in high. The current source is checked last.
- State IDLE:
  - No req_in high: stay. val_out 0, grant_out 0.
  - Any req_in high at cycle t: at t+1 enter SHOW, grant_out = one-hot(next), active_out 1, switch_out 1, counter 0, last = next.
- State SHOW, granted index g:
  - Each cycle val_out <= val_in[g], using the grant in effect after the current edge. Live tracking, latency 1 cycle from val_in to val_out.
  - Counter increments each cycle.
  - Dwell expiry (counter == DWELL_CYCLES-1) with hold_in low: search from g+1.
    - Different requester found: switch to it, switch_out 1, counter 0.
    - Only g requesting: keep g, counter 0, no switch_out.
    - None requesting: go IDLE.
  - hold_in high: counter saturates at DWELL_CYCLES-1, no rotation. On hold release, expiry applies on the next cycle.
  - req_in[g] drops, regardless of counter or hold_in: next cycle rearbitrate from g+1, as on expiry. None requesting: IDLE, val_out 0, grant_out 0, active_out 0.
- Exactly one update per cycle. Drop of req_in[g] takes precedence over expiry and hold.
- Requests for non-granted sources rising or falling mid-slot have no effect until the next arbitration point.
- grant_out is always one-hot or zero. switch_out never asserts in consecutive cycles unless the grant changes in consecutive cycles (drop-driven).
- rst_in mid-slot: all state returns to reset values on that edge. Pending requests are re-evaluated from index 0 the cycle after rst_in deasserts.
- Counter width: $clog2(DWELL_CYCLES). No overflow; counter resets or saturates as above.

Test Plan:
(Bench: NUM_SRC=4, DWELL_CYCLES=4, val_in[i] = 32'hA000_0000+i.)
1. Reset then req_in=4'b0000 for 20 cycles -> grant_out 0, val_out 0, active_out 0, switch_out never pulses.
2. req_in=4'b1111 from cycle 0 -> grants 0,1,2,3,0 with each held 4 cycles. switch_out pulses at each change. val_out steps A000_0000, A000_0001, A000_0002, A000_0003.
3. req_in=4'b0100 only -> grant_out 4'b0100 held indefinitely, switch_out pulses once, val_out A000_0002. Change val_in[2] to 1234_5678 -> val_out 1234_5678 one cycle later.
4. Grant on source 1, req_in=4'b1010. Drop req_in[1] at counter 1 -> next cycle grant 4'b1000, switch_out 1. Then drop req_in[3] -> IDLE, val_out 0.
5. req_in=4'b0011, hold_in=1 on grant 0 for 20 cycles -> grant stays 4'b0001. Release hold -> grant 4'b0010 on the following cycle.
6. Assert rst_in for 1 cycle while source 2 is granted -> next edge all outputs 0. With req_in=4'b1100 held, grant 4'b0100 one cycle after rst_in deasserts.
